// File: rtl/voice_allocator.sv
// Note-event scheduler: maps MIDI note-on/off events onto a pool of voice slots
// using per-slot key tags, envelope-finished flags and an age ranking.
//
// state  | meaning
// IDLE   | accepting events; a pending all-notes-off is serviced here first
// SCAN   | visiting one voice per cycle, recording candidate slots
// ASSIGN | applying the note-on/note-off to the chosen slot
module voice_allocator #(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = $clog2(VOICES)
) (
    input  logic               reg_clk,
    input  logic               reset_reg,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_is_on,
    input  logic [7:0]         ev_key,
    input  logic [7:0]         ev_vel,
    input  logic               all_off,
    input  logic [VOICES-1:0]  voice_free,
    output logic [VOICES-1:0]  keys_on,
    output logic               note_on,
    output logic [V_WIDTH-1:0] cur_key_adr,
    output logic [7:0]         cur_key_val,
    output logic [7:0]         cur_vel_on,
    output logic [7:0]         cur_vel_off,
    output logic [V_WIDTH:0]   active_keys
);

    typedef enum logic [1:0] {IDLE, SCAN, ASSIGN} state_t;

    state_t state, state_nxt;

    logic [6:0]         tag [VOICES];
    logic [V_WIDTH-1:0] age [VOICES];

    logic               all_off_pend;
    logic               h_on;
    logic [6:0]         h_key;
    logic [7:0]         h_vel;
    logic [V_WIDTH-1:0] scan_idx;

    logic               match_found, held_found, free_found, rel_found;
    logic [V_WIDTH-1:0] match_idx, held_idx, free_idx, rel_idx, rel_age, oldest_idx;

    logic               clear_now;
    logic               accept;
    logic               scan_last;
    logic [V_WIDTH-1:0] on_tgt;
    logic [V_WIDTH-1:0] tgt_age;
    logic               unused_key_msb;

    assign unused_key_msb = ev_key[7];

    // ev_ready depends only on state and the all-off latch
    assign clear_now = (state == IDLE) && all_off_pend;
    assign ev_ready  = (state == IDLE) && !all_off_pend;
    assign accept    = ev_ready && ev_valid;
    assign scan_last = (scan_idx == V_WIDTH'(VOICES - 1));

    always_comb begin
        on_tgt = oldest_idx;
        if (match_found)     on_tgt = match_idx;
        else if (free_found) on_tgt = free_idx;
        else if (rel_found)  on_tgt = rel_idx;
    end

    assign tgt_age = age[on_tgt];

    always_ff @(posedge reg_clk) begin
        if (reset_reg) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SCAN;
            SCAN:    if (scan_last) state_nxt = ASSIGN;
            ASSIGN:                 state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            keys_on      <= '0;
            note_on      <= 1'b0;
            cur_key_adr  <= '0;
            cur_key_val  <= '0;
            cur_vel_on   <= '0;
            cur_vel_off  <= '0;
            active_keys  <= '0;
            all_off_pend <= 1'b0;
            h_on         <= 1'b0;
            h_key        <= '0;
            h_vel        <= '0;
            scan_idx     <= '0;
            match_found  <= 1'b0;
            held_found   <= 1'b0;
            free_found   <= 1'b0;
            rel_found    <= 1'b0;
            match_idx    <= '0;
            held_idx     <= '0;
            free_idx     <= '0;
            rel_idx      <= '0;
            rel_age      <= '0;
            oldest_idx   <= '0;
            for (int u = 0; u < VOICES; u++) begin
                tag[u] <= '0;
                age[u] <= V_WIDTH'(u);
            end
        end else begin
            note_on <= 1'b0;
            if (all_off) all_off_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (clear_now) begin
                        // an all_off pulse in this same cycle is absorbed here
                        keys_on      <= '0;
                        active_keys  <= '0;
                        all_off_pend <= 1'b0;
                    end else if (accept) begin
                        h_on        <= ev_is_on && (ev_vel != 8'd0);
                        h_key       <= ev_key[6:0];
                        h_vel       <= ev_vel;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        held_found  <= 1'b0;
                        free_found  <= 1'b0;
                        rel_found   <= 1'b0;
                    end
                end

                SCAN: begin
                    if (!match_found && tag[scan_idx] == h_key &&
                        (keys_on[scan_idx] || !voice_free[scan_idx])) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!held_found && keys_on[scan_idx] && tag[scan_idx] == h_key) begin
                        held_found <= 1'b1;
                        held_idx   <= scan_idx;
                    end
                    if (!free_found && voice_free[scan_idx] && !keys_on[scan_idx]) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (!keys_on[scan_idx] && !voice_free[scan_idx] &&
                        (!rel_found || age[scan_idx] > rel_age)) begin
                        rel_found <= 1'b1;
                        rel_idx   <= scan_idx;
                        rel_age   <= age[scan_idx];
                    end
                    if (age[scan_idx] == V_WIDTH'(VOICES - 1)) oldest_idx <= scan_idx;
                    scan_idx <= scan_idx + V_WIDTH'(1);
                end

                ASSIGN: begin
                    if (h_on) begin
                        for (int u = 0; u < VOICES; u++) begin
                            if (age[u] < tgt_age) age[u] <= age[u] + V_WIDTH'(1);
                        end
                        age[on_tgt]     <= '0;
                        tag[on_tgt]     <= h_key;
                        keys_on[on_tgt] <= 1'b1;
                        if (!keys_on[on_tgt]) active_keys <= active_keys + (V_WIDTH+1)'(1);
                        cur_key_adr <= on_tgt;
                        cur_key_val <= {1'b0, h_key};
                        cur_vel_on  <= h_vel;
                        note_on     <= 1'b1;
                    end else if (held_found) begin
                        keys_on[held_idx] <= 1'b0;
                        active_keys       <= active_keys - (V_WIDTH+1)'(1);
                        cur_key_adr       <= held_idx;
                        cur_key_val       <= {1'b0, h_key};
                        cur_vel_off       <= h_vel;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule
